// File: rtl/sel_mask_accum.sv
`default_nettype none
// ============================================================================
// Module   : sel_mask_accum
// Brief    : Accumulates a per-group lane selection mask from a stream of
//            select indices, with a term budget, duplicate/out-of-range
//            flags and a valid/ready group-close handshake.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module sel_mask_accum #(
    parameter int NUM_OUT = 8,
    parameter int SEL_W   = 3,
    parameter int BUDGET  = 4,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_last,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] mask_out,
    output logic [CNT_W-1:0]   set_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               dup_pulse,
    output logic               drop_pulse
);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic [NUM_OUT-1:0] c_LANE0  = {{(NUM_OUT-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   c_BUDGET = CNT_W'(BUDGET);
    localparam logic [CNT_W-1:0]   c_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dup_q, dup_d;
    logic               drop_q, drop_d;

    logic               w_accept;
    logic               w_out_of_range;
    logic [NUM_OUT-1:0] w_onehot;
    logic               w_hit;

    assign w_accept       = in_valid && (state_q == ST_ACCUM);
    assign w_out_of_range = int'(in_sel) >= NUM_OUT;
    // The shift yields zero for out-of-range indices, so w_hit is safe to
    // evaluate for any select value.
    assign w_onehot       = c_LANE0 << in_sel;
    assign w_hit          = |(mask_q & w_onehot);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        dup_d   = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_out_of_range) begin
                        drop_d = 1'b1;
                    end else if (w_hit) begin
                        dup_d = 1'b1;
                    end else if (cnt_q == c_BUDGET) begin
                        drop_d = 1'b1;
                    end else begin
                        mask_d = mask_q | w_onehot;
                        cnt_d  = cnt_q + c_ONE;
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                mask_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset and clear have identical effect; a beat seen alongside either
    // is dropped silently.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q <= ST_ACCUM;
            mask_q  <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            drop_q  <= drop_d;
        end
    end

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_HOLD);
    assign mask_out   = mask_q;
    assign set_count  = cnt_q;
    assign dup_pulse  = dup_q;
    assign drop_pulse = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_sel_mask_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_mask_accum
// Brief    : Directed bench for sel_mask_accum (8-lane and 6-lane instances)
//            with a reference-model scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sel_mask_accum;

    logic       clk = 1'b0;
    logic       reset, clear, in_valid, in_last, out_ready;
    logic [2:0] in_sel;

    wire        a_ir, a_ov, a_dup, a_drop;
    wire  [7:0] a_mask;
    wire  [3:0] a_cnt;
    wire        b_ir, b_ov, b_dup, b_drop;
    wire  [5:0] b_mask;
    wire  [3:0] b_cnt;

    always #5 clk = ~clk;

    sel_mask_accum #(.NUM_OUT(8), .SEL_W(3), .BUDGET(4), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_sel(in_sel), .in_last(in_last), .in_ready(a_ir),
        .mask_out(a_mask), .set_count(a_cnt), .out_valid(a_ov),
        .out_ready(out_ready), .dup_pulse(a_dup), .drop_pulse(a_drop)
    );

    sel_mask_accum #(.NUM_OUT(6), .SEL_W(3), .BUDGET(4), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_sel(in_sel), .in_last(in_last), .in_ready(b_ir),
        .mask_out(b_mask), .set_count(b_cnt), .out_valid(b_ov),
        .out_ready(out_ready), .dup_pulse(b_dup), .drop_pulse(b_drop)
    );

    typedef struct {
        bit [7:0] mask;
        int       cnt;
        bit       hold;
        bit       dup;
        bit       drop;
    } mst_t;

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] cnt;
        logic       ov;
        logic       ir;
        logic       dup;
        logic       drop;
    } obs_t;

    obs_t qa[$];
    obs_t qb[$];
    mst_t ma, mb;
    int   total = 0;
    int   bad   = 0;

    function automatic mst_t mnext(mst_t s, int nout, bit rst, bit clr,
                                   bit v, logic [2:0] sel, bit last, bit ordy);
        mst_t r = s;
        r.dup  = 1'b0;
        r.drop = 1'b0;
        if (rst || clr) begin
            r.mask = '0;
            r.cnt  = 0;
            r.hold = 1'b0;
        end else if (s.hold) begin
            if (ordy) begin
                r.mask = '0;
                r.cnt  = 0;
                r.hold = 1'b0;
            end
        end else if (v) begin
            if (int'(sel) >= nout)   r.drop = 1'b1;
            else if (s.mask[sel])    r.dup  = 1'b1;
            else if (s.cnt == 4)     r.drop = 1'b1;
            else begin
                r.mask[sel] = 1'b1;
                r.cnt       = s.cnt + 1;
            end
            if (last) r.hold = 1'b1;
        end
        return r;
    endfunction

    function automatic obs_t to_obs(mst_t s);
        obs_t o;
        o.mask = s.mask;
        o.cnt  = 4'(s.cnt);
        o.ov   = s.hold;
        o.ir   = !s.hold;
        o.dup  = s.dup;
        o.drop = s.drop;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input bit rst, input bit clr, input bit v,
                        input logic [2:0] sel, input bit last, input bit ordy);
        obs_t ea, eb;
        reset     = rst;
        clear     = clr;
        in_valid  = v;
        in_sel    = sel;
        in_last   = last;
        out_ready = ordy;
        ma = mnext(ma, 8, rst, clr, v, sel, last, ordy);
        mb = mnext(mb, 6, rst, clr, v, sel, last, ordy);
        qa.push_back(to_obs(ma));
        qb.push_back(to_obs(mb));
        @(posedge clk);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_mask", {24'd0, a_mask}, {24'd0, ea.mask});
        chk("a_cnt",  {28'd0, a_cnt},  {28'd0, ea.cnt});
        chk("a_ov",   {31'd0, a_ov},   {31'd0, ea.ov});
        chk("a_ir",   {31'd0, a_ir},   {31'd0, ea.ir});
        chk("a_dup",  {31'd0, a_dup},  {31'd0, ea.dup});
        chk("a_drop", {31'd0, a_drop}, {31'd0, ea.drop});
        chk("b_mask", {26'd0, b_mask}, {24'd0, eb.mask});
        chk("b_cnt",  {28'd0, b_cnt},  {28'd0, eb.cnt});
        chk("b_ov",   {31'd0, b_ov},   {31'd0, eb.ov});
        chk("b_ir",   {31'd0, b_ir},   {31'd0, eb.ir});
        chk("b_dup",  {31'd0, b_dup},  {31'd0, eb.dup});
        chk("b_drop", {31'd0, b_drop}, {31'd0, eb.drop});
        chk("a_popcount", {28'd0, a_cnt}, $countones(a_mask));
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        in_sel = 3'd0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        step(1, 0, 0, 3'd0, 0, 0);
        chk("reset_mask", {24'd0, a_mask}, 32'h0);
        chk("reset_ir",   {31'd0, a_ir},   32'h1);

        // Basic group 2,5,7
        step(0, 0, 1, 3'd2, 0, 1);
        step(0, 0, 1, 3'd5, 0, 1);
        step(0, 0, 1, 3'd7, 1, 1);
        chk("grp1_mask", {24'd0, a_mask}, 32'hA4);
        chk("grp1_cnt",  {28'd0, a_cnt},  32'd3);
        chk("grp1_ov",   {31'd0, a_ov},   32'd1);
        step(0, 0, 0, 3'd0, 0, 1);
        chk("grp1_rel_mask", {24'd0, a_mask}, 32'h0);
        chk("grp1_rel_ir",   {31'd0, a_ir},   32'd1);

        // Duplicates 3,3,3 then last 0
        step(0, 0, 1, 3'd3, 0, 0);
        chk("dup_first", {31'd0, a_dup}, 32'd0);
        step(0, 0, 1, 3'd3, 0, 0);
        chk("dup_second", {31'd0, a_dup}, 32'd1);
        step(0, 0, 1, 3'd3, 0, 0);
        chk("dup_third", {31'd0, a_dup}, 32'd1);
        step(0, 0, 1, 3'd0, 1, 0);
        chk("dup_mask", {24'd0, a_mask}, 32'h09);
        chk("dup_cnt",  {28'd0, a_cnt},  32'd2);
        step(0, 0, 0, 3'd0, 0, 1);

        // Budget exhaustion 0..6
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 3'(i), (i == 6), 0);
            chk("budget_drop", {31'd0, a_drop}, (i >= 4) ? 32'd1 : 32'd0);
        end
        chk("budget_mask", {24'd0, a_mask}, 32'h0F);
        chk("budget_cnt",  {28'd0, a_cnt},  32'd4);
        step(0, 0, 0, 3'd0, 0, 1);

        // Out-of-range on the 6-lane instance
        step(0, 0, 1, 3'd6, 0, 0);
        chk("oor6_drop", {31'd0, b_drop}, 32'd1);
        step(0, 0, 1, 3'd7, 0, 0);
        chk("oor7_drop", {31'd0, b_drop}, 32'd1);
        step(0, 0, 1, 3'd1, 1, 0);
        chk("oor_mask", {26'd0, b_mask}, 32'h02);
        chk("oor_cnt",  {28'd0, b_cnt},  32'd1);
        step(0, 0, 0, 3'd0, 0, 1);

        // Back-pressure with beats presented while holding
        step(0, 0, 1, 3'd0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 3'd4, 0, 0);
            chk("bp_ir",   {31'd0, a_ir},   32'd0);
            chk("bp_ov",   {31'd0, a_ov},   32'd1);
            chk("bp_mask", {24'd0, a_mask}, 32'h01);
        end
        step(0, 0, 1, 3'd4, 0, 1);
        chk("bp_rel_mask", {24'd0, a_mask}, 32'h0);
        step(0, 0, 0, 3'd0, 0, 0);
        chk("bp_no_bit4", {31'd0, a_mask[4]}, 32'd0);

        // Clear mid-group with a simultaneous beat
        step(0, 0, 1, 3'd1, 0, 0);
        step(0, 0, 1, 3'd4, 0, 0);
        chk("pre_clear_mask", {24'd0, a_mask}, 32'h12);
        step(0, 1, 1, 3'd7, 0, 0);
        chk("clear_mask",  {24'd0, a_mask}, 32'h0);
        chk("clear_flags", {30'd0, a_dup, a_drop}, 32'd0);

        // Reset while holding
        step(0, 0, 1, 3'd3, 1, 0);
        chk("hold_ov", {31'd0, a_ov}, 32'd1);
        step(1, 0, 0, 3'd0, 0, 0);
        chk("rst_hold_ov", {31'd0, a_ov}, 32'd0);
        chk("rst_hold_ir", {31'd0, a_ir}, 32'd1);

        // Consecutive offending beats: dup, budget drop, dup
        for (int i = 0; i < 4; i++) step(0, 0, 1, 3'(i), 0, 0);
        step(0, 0, 1, 3'd3, 0, 0);
        chk("seq_dup", {31'd0, a_dup}, 32'd1);
        step(0, 0, 1, 3'd5, 0, 0);
        chk("seq_drop", {31'd0, a_drop}, 32'd1);
        step(0, 0, 1, 3'd0, 1, 0);
        chk("seq_dup2", {31'd0, a_dup}, 32'd1);
        step(0, 0, 0, 3'd0, 0, 1);

        // Group closing with zero selections (6-lane instance)
        step(0, 0, 1, 3'd7, 1, 0);
        chk("empty_ov",  {31'd0, b_ov},  32'd1);
        chk("empty_cnt", {28'd0, b_cnt}, 32'd0);
        step(0, 0, 0, 3'd0, 0, 1);
        step(0, 0, 0, 3'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
